// File: rtl/game_ctrl.sv
// Game controller: button debounce, frame tick and ATTRACT/PLAY/DYING/OVER sequencing.
// Define GAME_CTRL_DEBUG_EN to let the debug input force the game back to ATTRACT.
module game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DEATH_FRAMES    = 60,
   parameter int ARM_FRAMES      = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       vsync,
   input  logic       hit,
   input  logic       debug,
   output logic [1:0] game_state,
   output logic       halt,
   output logic       restart,
   output logic [3:0] btn_clean,
   output logic       frame_tick
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int MAXF = (DEATH_FRAMES > ARM_FRAMES) ? DEATH_FRAMES : ARM_FRAMES;
   localparam int FW   = (MAXF > 0) ? $clog2(MAXF + 1) : 1;

   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] DEATH_LAST = FW'(DEATH_FRAMES);
   localparam logic [FW-1:0] ARM_LAST   = FW'(ARM_FRAMES);

   typedef enum logic [1:0] {
      ATTRACT = 2'd0,
      PLAY    = 2'd1,
      OVER    = 2'd2,
      DYING   = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
   logic            halt_reg, halt_next;
   logic            restart_reg, restart_next;
   logic [3:0]      btn_clean_w;
   logic [3:0]      btn_prev_reg;
   logic            press_reg;
   logic            vsync_reg, vsync_prev_reg;
   logic            frame_tick_reg;

   // Each button gets its own stability counter; any bounce resets it.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_db
         logic [DW-1:0] cnt_reg;
         logic          clean_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_reg   <= '0;
               clean_reg <= 1'b0;
            end else if (btn[gi] == clean_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
               cnt_reg   <= '0;
               clean_reg <= btn[gi];
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign btn_clean_w[gi] = clean_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_prev_reg   <= '0;
         press_reg      <= 1'b0;
         vsync_reg      <= 1'b0;
         vsync_prev_reg <= 1'b0;
         frame_tick_reg <= 1'b0;
      end else begin
         btn_prev_reg   <= btn_clean_w;
         press_reg      <= |(btn_clean_w & ~btn_prev_reg);
         vsync_reg      <= vsync;
         vsync_prev_reg <= vsync_reg;
         frame_tick_reg <= vsync_prev_reg & ~vsync_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ATTRACT;
         frame_cnt_reg <= '0;
         halt_reg      <= 1'b1;
         restart_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_cnt_reg <= frame_cnt_next;
         halt_reg      <= halt_next;
         restart_reg   <= restart_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      frame_cnt_next = frame_cnt_reg;
      restart_next   = 1'b0;
      case (state_reg)
         ATTRACT: begin
            if (press_reg) begin
               state_next   = PLAY;
               restart_next = 1'b1;
            end
         end
         PLAY: begin
            // hit outranks a coincident press, which is simply dropped
            if (hit) begin
               state_next     = DYING;
               frame_cnt_next = '0;
            end
         end
         DYING: begin
            if (frame_tick_reg) begin
               if (frame_cnt_reg + 1'b1 == DEATH_LAST) begin
                  state_next     = OVER;
                  frame_cnt_next = '0;
               end else begin
                  frame_cnt_next = frame_cnt_reg + 1'b1;
               end
            end
         end
         OVER: begin
            if (press_reg && frame_cnt_reg == ARM_LAST) begin
               state_next     = PLAY;
               frame_cnt_next = '0;
               restart_next   = 1'b1;
            end else if (frame_tick_reg && frame_cnt_reg != ARM_LAST) begin
               frame_cnt_next = frame_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next     = ATTRACT;
            frame_cnt_next = '0;
         end
      endcase
`ifdef GAME_CTRL_DEBUG_EN
      if (debug) begin
         state_next     = ATTRACT;
         frame_cnt_next = '0;
         restart_next   = 1'b0;
      end
`endif
      halt_next = (state_next != PLAY);
   end

`ifndef GAME_CTRL_DEBUG_EN
   logic unused_debug;
   assign unused_debug = debug;
`endif

   assign game_state = state_reg;
   assign halt       = halt_reg;
   assign restart    = restart_reg;
   assign btn_clean  = btn_clean_w;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl; state transitions are scored against a queue
// of expected {state, restart, halt} entries pushed by the scenario tasks.
module tb_game_ctrl;

   localparam int DEB   = 4;
   localparam int DEATH = 3;
   localparam int ARM   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;
   logic       vsync;
   logic       hit;
   logic       debug;
   logic [1:0] game_state;
   logic       halt;
   logic       restart;
   logic [3:0] btn_clean;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] gs;
      logic       rs;
      logic       ht;
   } exp_t;

   exp_t       exp_q[$];
   bit         mon_en = 1'b0;
   logic [1:0] prev_gs;

   game_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .DEATH_FRAMES   (DEATH),
      .ARM_FRAMES     (ARM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .vsync     (vsync),
      .hit       (hit),
      .debug     (debug),
      .game_state(game_state),
      .halt      (halt),
      .restart   (restart),
      .btn_clean (btn_clean),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every state change must match the next queued entry,
   // and restart may only be seen together with a state change.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (game_state !== prev_gs) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_transition got state=%0d from %0d, required no change",
                        game_state, prev_gs);
            end else begin
               e = exp_q.pop_front();
               if (game_state !== e.gs || restart !== e.rs || halt !== e.ht) begin
                  errors++;
                  $display("FAIL transition got state=%0d restart=%0b halt=%0b required state=%0d restart=%0b halt=%0b",
                           game_state, restart, halt, e.gs, e.rs, e.ht);
               end else begin
                  $display("transition state=%0d restart=%0b halt=%0b ok", game_state, restart, halt);
               end
            end
         end else begin
            checks++;
            if (restart !== 1'b0) begin
               errors++;
               $display("FAIL stray_restart got restart=%0b in state=%0d required 0", restart, game_state);
            end
         end
      end
      prev_gs = game_state;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [1:0] gs, input logic rs, input logic ht);
      exp_t e;
      e.gs = gs;
      e.rs = rs;
      e.ht = ht;
      exp_q.push_back(e);
   endtask

   task automatic press(input int b);
      btn[b] = 1'b1;
      cyc(DEB + 2);
      btn[b] = 1'b0;
      cyc(DEB + 2);
   endtask

   // Drops vsync and waits (bounded) for frame_tick, then lets the FSM act on it.
   task automatic do_frame();
      bit found = 1'b0;
      vsync = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         cyc(1);
         if (frame_tick === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL frame_tick_seen got 0 required 1");
      end
      cyc(1);
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL frame_tick_width got %0b required 0", frame_tick);
      end
      vsync = 1'b1;
      cyc(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      btn   = 4'b0;
      vsync = 1'b1;
      hit   = 1'b0;
      debug = 1'b0;
      cyc(3);
      checks++;
      if (game_state !== 2'd0 || halt !== 1'b1 || restart !== 1'b0 ||
          btn_clean !== 4'b0 || frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got state=%0d halt=%0b restart=%0b clean=%b tick=%0b required 0 1 0 0000 0",
                  game_state, halt, restart, btn_clean, frame_tick);
      end else begin
         $display("reset state ok");
      end
      reset = 1'b0;
      cyc(2);
      prev_gs = game_state;
      mon_en  = 1'b1;
   endtask

   task automatic test_debounce_start();
      logic exp_b;
      btn[0] = 1'b1;
      cyc(3);
      checks++;
      if (btn_clean[0] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_rejected got %0b required 0", btn_clean[0]);
      end
      btn[0] = 1'b0;
      cyc(1);
      btn[0] = 1'b1;
      push_exp(2'd1, 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         exp_b = (k >= DEB);
         checks++;
         if (btn_clean[0] !== exp_b) begin
            errors++;
            $display("FAIL debounce_k%0d got %0b required %0b", k, btn_clean[0], exp_b);
         end
      end
      checks++;
      if (game_state !== 2'd1 || halt !== 1'b0 || restart !== 1'b1) begin
         errors++;
         $display("FAIL start_play got state=%0d halt=%0b restart=%0b required 1 0 1",
                  game_state, halt, restart);
      end
      cyc(1);
      checks++;
      if (restart !== 1'b0) begin
         errors++;
         $display("FAIL restart_width got %0b required 0", restart);
      end
      btn[0] = 1'b0;
      cyc(DEB + 2);
      checks++;
      if (btn_clean !== 4'b0) begin
         errors++;
         $display("FAIL release_clean got %b required 0000", btn_clean);
      end
   endtask

   task automatic test_hit_press();
      btn[1] = 1'b1;
      cyc(DEB + 1);
      hit = 1'b1;
      push_exp(2'd3, 1'b0, 1'b1);
      cyc(1);
      hit = 1'b0;
      checks++;
      if (game_state !== 2'd3 || halt !== 1'b1 || restart !== 1'b0) begin
         errors++;
         $display("FAIL hit_wins got state=%0d halt=%0b restart=%0b required 3 1 0",
                  game_state, halt, restart);
      end
      btn[1] = 1'b0;
      cyc(DEB + 2);
   endtask

   task automatic test_dying();
      press(2);
      checks++;
      if (game_state !== 2'd3) begin
         errors++;
         $display("FAIL dying_press got state=%0d required 3", game_state);
      end
      for (int f = 1; f <= DEATH; f++) begin
         if (f == DEATH) push_exp(2'd2, 1'b0, 1'b1);
         do_frame();
         checks++;
         if (game_state !== ((f == DEATH) ? 2'd2 : 2'd3)) begin
            errors++;
            $display("FAIL dying_frame%0d got state=%0d required %0d", f, game_state,
                     (f == DEATH) ? 2 : 3);
         end
      end
   endtask

   task automatic test_over();
      do_frame();
      press(0);
      checks++;
      if (game_state !== 2'd2 || halt !== 1'b1) begin
         errors++;
         $display("FAIL over_early_press got state=%0d halt=%0b required 2 1", game_state, halt);
      end
      btn[3] = 1'b1;
      cyc(DEB + 2);
      do_frame();
      cyc(3);
      checks++;
      if (game_state !== 2'd2) begin
         errors++;
         $display("FAIL over_held_button got state=%0d required 2", game_state);
      end
      btn[3] = 1'b0;
      cyc(DEB + 2);
      push_exp(2'd1, 1'b1, 1'b0);
      press(0);
      checks++;
      if (game_state !== 2'd1 || halt !== 1'b0) begin
         errors++;
         $display("FAIL over_armed_press got state=%0d halt=%0b required 1 0", game_state, halt);
      end
   endtask

   task automatic test_debug();
      debug = 1'b1;
`ifdef GAME_CTRL_DEBUG_EN
      push_exp(2'd0, 1'b0, 1'b1);
`endif
      cyc(1);
      debug = 1'b0;
      checks++;
`ifdef GAME_CTRL_DEBUG_EN
      if (game_state !== 2'd0 || halt !== 1'b1) begin
         errors++;
         $display("FAIL debug_force got state=%0d halt=%0b required 0 1", game_state, halt);
      end
      push_exp(2'd1, 1'b1, 1'b0);
      press(0);
`else
      if (game_state !== 2'd1 || halt !== 1'b0) begin
         errors++;
         $display("FAIL debug_ignored got state=%0d halt=%0b required 1 0", game_state, halt);
      end
`endif
      cyc(2);
   endtask

   task automatic test_reset_mid();
      hit = 1'b1;
      push_exp(2'd3, 1'b0, 1'b1);
      cyc(1);
      hit = 1'b0;
      do_frame();
      reset = 1'b1;
      push_exp(2'd0, 1'b0, 1'b1);
      cyc(1);
      checks++;
      if (game_state !== 2'd0 || halt !== 1'b1 || restart !== 1'b0 || btn_clean !== 4'b0) begin
         errors++;
         $display("FAIL reset_mid got state=%0d halt=%0b restart=%0b clean=%b required 0 1 0 0000",
                  game_state, halt, restart, btn_clean);
      end
      reset = 1'b0;
      cyc(3);
   endtask

   initial begin
      test_reset();
      test_debounce_start();
      test_hit_press();
      test_dying();
      test_over();
      test_debug();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required before a raw button change is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter DEATH_FRAMES, default 60: frames spent in DYING before OVER.
REQ-003 SHALL have parameter ARM_FRAMES, default 30: frames in OVER during which presses are ignored.
REQ-004 SHALL have port clk, input, 1: pixel clock (25 MHz divided clock); the only clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port btn, input, 4: raw buttons {down,up,right,left}, already in the clk domain.
REQ-007 SHALL have port vsync, input, 1: active-low vertical sync from the VGA timing block.
REQ-008 SHALL have port hit, input, 1: per-pixel dino/obstacle overlap from the renderer.
REQ-009 SHALL have port debug, input, 1: force-to-ATTRACT request; used only when GAME_CTRL_DEBUG_EN is defined.
REQ-010 SHALL have port game_state, output, 2: 0 ATTRACT, 1 PLAY, 2 OVER, 3 DYING.
REQ-011 SHALL have port halt, output, 1: freezes the movement, score and obstacle stages.
REQ-012 SHALL have port restart, output, 1: one-cycle pulse that clears the downstream position and score.
REQ-013 SHALL have port btn_clean, output, 4: debounced button levels.
REQ-014 SHALL have port frame_tick, output, 1: one-cycle pulse on each vsync falling edge.

Function
REQ-015 SHALL debounce each button independently: the btn_clean bit takes the raw value after raw != clean holds for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that bit's counter.
REQ-016 SHALL generate an internal press pulse when any btn_clean bit rises (registered compare against the previous btn_clean); simultaneous rises produce one pulse.
REQ-017 SHALL register vsync and assert frame_tick one cycle after vsync is sampled 1 then 0.
REQ-018 SHALL make every output a register output, with no combinational path from input to output.
REQ-019 In ATTRACT, SHALL hold halt=1; on press, SHALL move to PLAY and pulse restart on the same edge as the state change.
REQ-020 In PLAY, SHALL hold halt=0; hit=1 in any cycle SHALL move to DYING on the next edge and set halt=1.
REQ-021 If hit and press occur in the same PLAY cycle, hit SHALL win and the press SHALL be discarded.
REQ-022 In DYING, SHALL clear the frame counter on entry, increment it on each frame_tick, and move to OVER on the tick that makes it equal to DEATH_FRAMES; presses and hit SHALL be ignored.
REQ-023 In OVER, SHALL hold halt=1, clear the frame counter on entry and count frame_ticks up to a saturation value of ARM_FRAMES.
REQ-024 In OVER, a press before the count reaches ARM_FRAMES SHALL be ignored.
REQ-025 In OVER, a press after the count reaches ARM_FRAMES SHALL move to PLAY and pulse restart.
REQ-026 SHALL use a frame counter of width clog2(max(DEATH_FRAMES,ARM_FRAMES)+1), with no wrap-around.
REQ-027 SHALL hold restart high for exactly one cycle per transition into PLAY and never assert it in any other case.
REQ-028 SHALL make a button already held at entry to ATTRACT or OVER unable to trigger a transition; only a new rising edge counts.

Reset
REQ-029 SHALL, while reset=1, set state ATTRACT (game_state=0), halt=1, restart=0, btn_clean=0, frame_tick=0, and clear all counters and edge registers.
REQ-030 SHALL let reset asserted mid-DYING or mid-OVER override all transitions in that cycle and take the block to ATTRACT on the next edge.

Configuration
REQ-031 With GAME_CTRL_DEBUG_EN defined, SHALL make debug=1 in any state force ATTRACT and halt=1 on the next edge, with priority below reset and above hit/press, and no restart pulse.
REQ-032 With GAME_CTRL_DEBUG_EN undefined, SHALL keep the debug port, ignore it and add no logic for it.

Verification (DEBOUNCE_CYCLES=4, DEATH_FRAMES=3, ARM_FRAMES=2)
REQ-033 SHALL cover: reset held 3 cycles -> game_state=0, halt=1, restart=0, btn_clean=0.
REQ-034 SHALL cover: btn[0]=1 for 3 cycles, then 0, then 1 for 6 cycles -> btn_clean[0] rises only after 4 stable cycles; then game_state=1, halt=0, and restart high for exactly 1 cycle.
REQ-035 SHALL cover: in PLAY, hit and a new press in the same cycle -> game_state=3 and halt=1 next edge, with no restart pulse.
REQ-036 SHALL cover: in DYING, 3 vsync falling edges -> game_state=2 on the 3rd frame_tick edge; a press during DYING has no effect.
REQ-037 SHALL cover: in OVER, a press after 1 frame is ignored and a press after 2 frames -> game_state=1 with a 1-cycle restart pulse.
REQ-038 SHALL cover: with GAME_CTRL_DEBUG_EN, debug=1 in PLAY -> game_state=0 next edge; without it -> game_state stays 1.
